// File: rtl/rand_matrix_filler_pkg.sv
//------------------------------------------------------------------------------
// Module  : rand_matrix_filler_pkg
// Purpose : Shared matrix dimensions, element widths and filler FSM encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rand_matrix_filler_pkg;

  localparam int MAX_DIM    = 5;
  localparam int ELEM_W     = 4;
  localparam int ADDR_W     = 5;
  localparam int SAMPLE_GAP = 4;
  localparam int DIM_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic dim_legal(input logic [DIM_W-1:0] dim);
    return (dim != '0) && (dim <= DIM_W'(MAX_DIM));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rand_matrix_filler_if.sv
//------------------------------------------------------------------------------
// Module  : rand_matrix_filler_if
// Purpose : Valid/ready write port from the filler into matrix storage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rand_matrix_filler_if #(
  parameter int ELEM_W = 4,
  parameter int ADDR_W = 5
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_row;
  logic [2:0]        wr_col;
  logic [ELEM_W-1:0] wr_data;

  modport master (
    output wr_valid, wr_addr, wr_row, wr_col, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_row, wr_col, wr_data,
    output wr_ready
  );
endinterface

`default_nettype wire

// File: rtl/rand_matrix_filler_gap_timer.sv
//------------------------------------------------------------------------------
// Module  : rand_matrix_filler_gap_timer
// Purpose : Loadable down-counter with zero flag; spaces LFSR samples.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rand_matrix_filler_gap_timer #(
  parameter int WIDTH = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  input  wire logic             en,
  output logic                  zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/rand_matrix_filler.sv
//------------------------------------------------------------------------------
// Module  : rand_matrix_filler
// Purpose : Streams a rows x cols matrix of bounded LFSR samples, row-major.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rand_matrix_filler
  import rand_matrix_filler_pkg::*;
#(
  parameter int SAMPLE_GAP_P = SAMPLE_GAP
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  input  wire logic              abort,
  input  wire logic [DIM_W-1:0]  rows,
  input  wire logic [DIM_W-1:0]  cols,
  input  wire logic [ELEM_W-1:0] max_val,
  output logic      [ELEM_W-1:0] rnd_max,
  input  wire logic [ELEM_W-1:0] rnd_value,
  rand_matrix_filler_if.master   wr,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int GAP_W = $clog2(SAMPLE_GAP_P + 1);

  state_t              r_state;
  logic [DIM_W-1:0]    r_rows, r_cols, r_row, r_col;
  logic [ELEM_W-1:0]   r_max, r_data, r_rnd_max;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_valid, r_busy, r_done, r_err;

  logic w_legal, w_last, w_accept, w_abort, w_gap_load, w_gap_en, w_gap_zero;

  always_comb begin
    w_legal    = dim_legal(rows) && dim_legal(cols);
    w_last     = (r_row == r_rows - DIM_W'(1)) && (r_col == r_cols - DIM_W'(1));
    w_abort    = abort && (r_state != ST_IDLE);
    w_accept   = (r_state == ST_WRITE) && r_valid && wr.wr_ready && !w_abort;
    // Loading SAMPLE_GAP and sampling on the zero cycle gives SAMPLE_GAP+1 clocks start-to-valid.
    w_gap_load = ((r_state == ST_IDLE) && start && w_legal) || (w_accept && !w_last);
    w_gap_en   = (r_state == ST_WAIT) && !w_abort;
  end

  rand_matrix_filler_gap_timer #(.WIDTH(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_gap_load),
    .load_val (GAP_W'(SAMPLE_GAP_P)),
    .en       (w_gap_en),
    .zero     (w_gap_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rows    <= '0;
      r_cols    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_max     <= '0;
      r_data    <= '0;
      r_rnd_max <= '0;
      r_addr    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_abort) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && w_legal) begin
              r_rows    <= rows;
              r_cols    <= cols;
              r_max     <= max_val;
              r_rnd_max <= max_val;
              r_row     <= '0;
              r_col     <= '0;
              r_addr    <= '0;
              r_busy    <= 1'b1;
              r_state   <= ST_WAIT;
            end else if (start) begin
              r_err <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (w_gap_zero) begin
              // Defensive clamp in case the LFSR ignores its bound.
              r_data  <= (rnd_value > r_max) ? r_max : rnd_value;
              r_valid <= 1'b1;
              r_state <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (w_accept) begin
              r_valid <= 1'b0;
              if (w_last) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                if (r_col == r_cols - DIM_W'(1)) begin
                  r_col <= '0;
                  r_row <= r_row + DIM_W'(1);
                end else begin
                  r_col <= r_col + DIM_W'(1);
                end
                r_addr  <= r_addr + ADDR_W'(1);
                r_state <= ST_WAIT;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign wr.wr_valid = r_valid;
  assign wr.wr_addr  = r_addr;
  assign wr.wr_row   = r_row;
  assign wr.wr_col   = r_col;
  assign wr.wr_data  = r_data;
  assign rnd_max     = r_rnd_max;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rand_matrix_filler.sv
//------------------------------------------------------------------------------
// Module  : tb_rand_matrix_filler
// Purpose : Self-checking bench for rand_matrix_filler against a row-major model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rand_matrix_filler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] rows = 3'd0;
  logic [2:0] cols = 3'd0;
  logic [3:0] max_val = 4'd0;
  logic [3:0] rnd_value = 4'd0;
  logic [3:0] rnd_max;
  logic       busy, done, err;

  int errors = 0;
  int checks = 0;

  rand_matrix_filler_if #(.ELEM_W(4), .ADDR_W(5)) wr_if ();

  rand_matrix_filler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .rows      (rows),
    .cols      (cols),
    .max_val   (max_val),
    .rnd_max   (rnd_max),
    .rnd_value (rnd_value),
    .wr        (wr_if),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model: element k of an r x c fill is (k/c, k%c) at address k, value min(sample, max).
  task automatic run_fill(input int r, input int c, input int m, input int ready_pct,
                          input int fixed_rnd, input bit poke_start);
    int total, n, cyc;
    bit prev_valid, acc;
    logic [3:0] cur_rnd, exp_data, held_data;
    logic [4:0] held_addr;
    total = r * c; n = 0; cyc = 0; prev_valid = 0;
    held_data = '0; held_addr = '0;
    rows = 3'(r); cols = 3'(c); max_val = 4'(m);
    cur_rnd = rnd_value;
    start = 1'b1; step; start = 1'b0;
    checks++;
    if (busy !== 1'b1 || rnd_max !== 4'(m)) begin
      errors++;
      $display("FAIL fill_start: got busy=%b rnd_max=%0d expected busy=1 rnd_max=%0d", busy, rnd_max, m);
    end
    while (n < total && cyc < 3000) begin
      start = (poke_start && cyc == 2);
      if (poke_start && cyc == 2) begin rows = 3'd1; cols = 3'd1; end
      if (wr_if.wr_valid && !prev_valid) begin
        exp_data = (cur_rnd > 4'(m)) ? 4'(m) : cur_rnd;
        checks++;
        if (wr_if.wr_data !== exp_data) begin
          errors++;
          $display("FAIL wr_data: got %0d expected %0d (elem %0d)", wr_if.wr_data, exp_data, n);
        end
        held_data = wr_if.wr_data; held_addr = wr_if.wr_addr;
      end else if (wr_if.wr_valid) begin
        checks++;
        if (wr_if.wr_data !== held_data || wr_if.wr_addr !== held_addr) begin
          errors++;
          $display("FAIL hold: got data=%0d addr=%0d expected data=%0d addr=%0d",
                   wr_if.wr_data, wr_if.wr_addr, held_data, held_addr);
        end
      end
      checks++;
      if (err !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL fill_flags: got err=%b done=%b expected 0 0", err, done);
      end
      prev_valid = wr_if.wr_valid;
      wr_if.wr_ready = ($urandom_range(99) < 32'(ready_pct));
      acc = wr_if.wr_valid && wr_if.wr_ready;
      if (acc) begin
        checks++;
        if (wr_if.wr_addr !== 5'(n) || wr_if.wr_row !== 3'(n / c) || wr_if.wr_col !== 3'(n % c)) begin
          errors++;
          $display("FAIL wr_pos: got addr=%0d row=%0d col=%0d expected addr=%0d row=%0d col=%0d",
                   wr_if.wr_addr, wr_if.wr_row, wr_if.wr_col, n, n / c, n % c);
        end
        n++;
      end
      cur_rnd = (fixed_rnd >= 0) ? 4'(fixed_rnd) : 4'($urandom);
      rnd_value = cur_rnd;
      step; cyc++;
      if (acc) prev_valid = 0;
    end
    start = 1'b0;
    wr_if.wr_ready = 1'b0;
    checks++;
    if (n != total) begin
      errors++;
      $display("FAIL write_count: got %0d expected %0d", n, total);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wr_if.wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b valid=%b expected 1 0 0", done, busy, wr_if.wr_valid);
    end
    step;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: got %b expected 0", done);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, rnd_max, wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_row, wr_if.wr_col, wr_if.wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b valid=%b rnd_max=%0d expected all zero", busy, wr_if.wr_valid, rnd_max);
    end
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_basic_fill;
    run_fill(2, 3, 9, 100, -1, 0);
  endtask

  task automatic test_illegal_dims;
    int rr[2] = '{0, 2};
    int cc[2] = '{3, 6};
    for (int i = 0; i < 2; i++) begin
      rows = 3'(rr[i]); cols = 3'(cc[i]); max_val = 4'd5;
      start = 1'b1; step; start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || wr_if.wr_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal_err: got err=%b busy=%b valid=%b expected 1 0 0", err, busy, wr_if.wr_valid);
      end
      repeat (6) step;
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || wr_if.wr_valid !== 1'b0) begin
        errors++;
        $display("FAIL illegal_after: got err=%b busy=%b valid=%b expected 0 0 0", err, busy, wr_if.wr_valid);
      end
    end
  endtask

  task automatic test_latency_backpressure;
    bit early;
    rows = 3'd1; cols = 3'd1; max_val = 4'd9; rnd_value = 4'd7;
    wr_if.wr_ready = 1'b0;
    start = 1'b1; step; start = 1'b0;
    early = 0;
    for (int k = 1; k <= 4; k++) begin
      step;
      if (wr_if.wr_valid !== 1'b0) early = 1;
    end
    step;
    checks++;
    if (early || wr_if.wr_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: got early=%b valid_at_5=%b expected 0 1", early, wr_if.wr_valid);
    end
    checks++;
    if (wr_if.wr_data !== 4'd7 || wr_if.wr_addr !== 5'd0) begin
      errors++;
      $display("FAIL latency_data: got data=%0d addr=%0d expected 7 0", wr_if.wr_data, wr_if.wr_addr);
    end
    for (int k = 0; k < 7; k++) begin
      rnd_value = 4'($urandom);
      step;
      checks++;
      if (wr_if.wr_valid !== 1'b1 || wr_if.wr_data !== 4'd7 || wr_if.wr_addr !== 5'd0) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b data=%0d addr=%0d expected 1 7 0",
                 wr_if.wr_valid, wr_if.wr_data, wr_if.wr_addr);
      end
    end
    wr_if.wr_ready = 1'b1; step; wr_if.wr_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || wr_if.wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: got done=%b valid=%b expected 1 0", done, wr_if.wr_valid);
    end
    step;
  endtask

  task automatic test_bounds;
    run_fill(5, 5, 0, 100, -1, 0);
    run_fill(2, 2, 3, 100, 15, 0);
    max_val = 4'd12;
    repeat (2) step;
    checks++;
    if (rnd_max !== 4'd3) begin
      errors++;
      $display("FAIL rnd_max_hold: got %0d expected 3", rnd_max);
    end
  endtask

  task automatic test_abort;
    int n, cyc;
    bit quiet;
    n = 0; cyc = 0;
    rows = 3'd3; cols = 3'd3; max_val = 4'd9;
    start = 1'b1; step; start = 1'b0;
    while (cyc < 500 && !(wr_if.wr_valid && n == 3)) begin
      wr_if.wr_ready = wr_if.wr_valid;
      if (wr_if.wr_valid) n++;
      rnd_value = 4'($urandom);
      step; cyc++;
    end
    wr_if.wr_ready = 1'b0;
    checks++;
    if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== 5'd3) begin
      errors++;
      $display("FAIL abort_reach: got valid=%b addr=%0d expected 1 3", wr_if.wr_valid, wr_if.wr_addr);
    end
    abort = 1'b1; wr_if.wr_ready = 1'b1; step; abort = 1'b0; wr_if.wr_ready = 1'b0;
    checks++;
    if (wr_if.wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop: got valid=%b busy=%b done=%b expected 0 0 0", wr_if.wr_valid, busy, done);
    end
    quiet = 1;
    repeat (8) begin
      step;
      if (wr_if.wr_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL abort_quiet: got activity=1 expected 0");
    end
    run_fill(3, 3, 9, 100, -1, 0);
  endtask

  task automatic test_async_reset;
    rows = 3'd4; cols = 3'd4; max_val = 4'd11;
    start = 1'b1; step; start = 1'b0; step;
    checks++;
    if (busy !== 1'b1 || rnd_max !== 4'd11) begin
      errors++;
      $display("FAIL pre_reset: got busy=%b rnd_max=%0d expected 1 11", busy, rnd_max);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, rnd_max, wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b rnd_max=%0d valid=%b expected all zero", busy, rnd_max, wr_if.wr_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    step;
  endtask

  task automatic test_start_while_busy;
    run_fill(2, 2, 9, 70, -1, 1);
  endtask

  task automatic test_random_fills;
    for (int i = 0; i < 4; i++) begin
      run_fill(int'($urandom_range(5, 1)), int'($urandom_range(5, 1)),
               int'($urandom_range(15, 0)), 60, -1, 0);
    end
  endtask

  initial begin
    wr_if.wr_ready = 1'b0;
    test_reset;
    test_basic_fill;
    test_illegal_dims;
    test_latency_backpressure;
    test_bounds;
    test_abort;
    test_async_reset;
    test_start_while_busy;
    test_random_fills;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
